// File: rtl/dcache_line_ram_pkg.sv
// Shared constants, state encoding and transaction type for dcache_line_ram.
package dcache_line_ram_pkg;

  localparam int unsigned LINE_W   = 128;
  localparam int unsigned OFFSET_W = 4;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WB_WAIT = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] RESP    = 3'd3;
  localparam logic [2:0] HOLDOFF = 3'd4;

  typedef enum logic [1:0] {
    TXN_NONE  = 2'd0,
    TXN_WB    = 2'd1,
    TXN_RD    = 2'd2,
    TXN_WB_RD = 2'd3
  } txn_e;

  // True when the byte address has a nonzero line offset or bits beyond the line index.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[OFFSET_W-1:0] != '0) || ((addr >> (addr_w + OFFSET_W)) != '0);
  endfunction

endpackage

// File: rtl/dcache_line_ram_array.sv
// Single-port 128-bit line storage, synchronous read and write (block-RAM inferable).
module line_ram_array
  import dcache_line_ram_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [127:0]      wdata_i,
  output logic [127:0]      rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_line_ram.sv
// Fixed-latency line memory behind the rv32core Dcache port.
// Optional DCACHE_LINE_RAM_ADDR_CHECK_EN adds sticky ram_err_o and suppresses out-of-range accesses.
module dcache_line_ram
  import dcache_line_ram_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Dcache_rd_req_i,
  input  logic [31:0]  Dcache_rd_addr_i,
  input  logic         Dcache_wb_req_i,
  input  logic [31:0]  Dcache_wb_addr_i,
  input  logic [127:0] Dcache_data_ram_i,
  output logic [127:0] ram_data_o,
`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
  output logic         ram_err_o,
`endif
  output logic         ram_ready_o
);

`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  txn_e              txn_q, txn_d;
  logic [ADDR_W-1:0] wb_idx_q, wb_idx_d, rd_idx_q, rd_idx_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;
  logic              wb_ok_q, wb_ok_d, rd_ok_q, rd_ok_d;
  logic              ready_q, ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wb_bad, rd_bad;
  logic              ram_we, ram_re;
  logic [LINE_W-1:0] ram_rdata;

  assign wb_bad = addr_out_of_range(Dcache_wb_addr_i, ADDR_W);
  assign rd_bad = addr_out_of_range(Dcache_rd_addr_i, ADDR_W);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    txn_d      = txn_q;
    wb_idx_d   = wb_idx_q;
    rd_idx_d   = rd_idx_q;
    wb_line_d  = wb_line_q;
    wb_ok_d    = wb_ok_q;
    rd_ok_d    = rd_ok_q;
    ready_d    = 1'b0;
    rd_valid_d = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Dcache_wb_req_i || Dcache_rd_req_i) begin
          wb_idx_d  = Dcache_wb_addr_i[ADDR_W+OFFSET_W-1:OFFSET_W];
          rd_idx_d  = Dcache_rd_addr_i[ADDR_W+OFFSET_W-1:OFFSET_W];
          wb_line_d = Dcache_data_ram_i;
          wb_ok_d   = !(ADDR_CHECK && wb_bad);
          rd_ok_d   = !(ADDR_CHECK && rd_bad);
          cnt_d     = CNT_INIT;
          if (Dcache_wb_req_i) begin
            state_d = WB_WAIT;
            txn_d   = Dcache_rd_req_i ? TXN_WB_RD : TXN_WB;
          end else begin
            state_d = RD_WAIT;
            txn_d   = TXN_RD;
          end
        end
      end
      WB_WAIT: begin
        if (cnt_q == '0) begin
          ram_we = wb_ok_q;
          if (txn_q == TXN_WB_RD) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          // RAM output register captures the line on this edge; rd_valid gates it onto the port.
          ram_re     = 1'b1;
          rd_valid_d = rd_ok_q;
          state_d    = RESP;
          ready_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = HOLDOFF;
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      txn_q      <= TXN_NONE;
      wb_idx_q   <= '0;
      rd_idx_q   <= '0;
      wb_line_q  <= '0;
      wb_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txn_q      <= txn_d;
      wb_idx_q   <= wb_idx_d;
      rd_idx_q   <= rd_idx_d;
      wb_line_q  <= wb_line_d;
      wb_ok_q    <= wb_ok_d;
      rd_ok_q    <= rd_ok_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE &&
                 ((Dcache_wb_req_i && wb_bad) || (Dcache_rd_req_i && rd_bad))) begin
      err_q <= 1'b1;
    end
  end

  assign ram_err_o = err_q;
`endif

  line_ram_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i ((state_q == WB_WAIT) ? wb_idx_q : rd_idx_q),
    .wdata_i(wb_line_q),
    .rdata_o(ram_rdata)
  );

  assign ram_ready_o = ready_q;
  assign ram_data_o  = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dcache_line_ram.sv
// Self-checking bench for dcache_line_ram: directed literal cases plus randomized traffic vs a line-array model.
module tb_dcache_line_ram;

  localparam int L     = 4;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         Dcache_rd_req_i, Dcache_wb_req_i;
  logic [31:0]  Dcache_rd_addr_i, Dcache_wb_addr_i;
  logic [127:0] Dcache_data_ram_i;
  logic [127:0] ram_data_o;
  logic         ram_ready_o;
`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
  logic         ram_err_o;
`endif

  always #5 clk = ~clk;

  dcache_line_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .LATENCY(L)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .Dcache_rd_req_i  (Dcache_rd_req_i),
    .Dcache_rd_addr_i (Dcache_rd_addr_i),
    .Dcache_wb_req_i  (Dcache_wb_req_i),
    .Dcache_wb_addr_i (Dcache_wb_addr_i),
    .Dcache_data_ram_i(Dcache_data_ram_i),
    .ram_data_o       (ram_data_o),
`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
    .ram_err_o        (ram_err_o),
`endif
    .ram_ready_o      (ram_ready_o)
  );

  typedef struct {
    int           cyc;
    logic [127:0] data;
    bit           err;
  } exp_t;

  exp_t         expq[$];
  logic [127:0] mdl [DEPTH];
  bit           mdl_err = 1'b0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           ready_cnt = 0;
  int           last_rdy_cyc = -1;
  logic [127:0] last_rdy_data = '0;

  localparam logic [127:0] LIT1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LITA = {4{32'hAAAAAAAA}};
  localparam logic [127:0] LIT5 = {4{32'h55555555}};
  localparam logic [127:0] LIT11 = {4{32'h11111111}};
  localparam logic [127:0] LITC = {4{32'hCAFEF00D}};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] idx(input logic [31:0] a);
    return a[AW+3:4];
  endfunction

  function automatic bit bad(input logic [31:0] a);
    return (a[3:0] != 4'h0) || (a[31:AW+4] != '0);
  endfunction

  // Per-cycle compare: ready/data must match the scheduled expectation, else both are zero.
  always @(negedge clk) begin
    exp_t e;
    while (expq.size() != 0 && expq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_ready: expected ready at cycle %0d, still absent at cycle %0d", expq[0].cyc, cyc);
      void'(expq.pop_front());
    end
    checks++;
    if (expq.size() != 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      if (ram_ready_o !== 1'b1 || ram_data_o !== e.data) begin
        errors++;
        $display("FAIL resp_cycle%0d: ready=%b data=%h expected ready=1 data=%h", cyc, ram_ready_o, ram_data_o, e.data);
      end
`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
      checks++;
      if (ram_err_o !== e.err) begin
        errors++;
        $display("FAIL err_cycle%0d: ram_err_o=%b expected %b", cyc, ram_err_o, e.err);
      end
`endif
    end else if (ram_ready_o !== 1'b0 || ram_data_o !== '0) begin
      errors++;
      $display("FAIL quiet_cycle%0d: ready=%b data=%h expected ready=0 data=0", cyc, ram_ready_o, ram_data_o);
    end
    if (ram_ready_o === 1'b1) begin
      ready_cnt++;
      last_rdy_cyc  = cyc;
      last_rdy_data = ram_data_o;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit wb, input bit rd, input logic [31:0] wa, input logic [127:0] wd,
                     input logic [31:0] ra, input bit hold_extra, output int c);
    exp_t e;
    int   lat;
    c = cyc;
    Dcache_wb_req_i   = wb;
    Dcache_rd_req_i   = rd;
    Dcache_wb_addr_i  = wa;
    Dcache_rd_addr_i  = ra;
    Dcache_data_ram_i = wd;
    if (wb && !(CHK && bad(wa))) mdl[idx(wa)] = wd;
    if (CHK && ((wb && bad(wa)) || (rd && bad(ra)))) mdl_err = 1'b1;
    lat    = (wb && rd) ? 2 * L + 1 : L + 1;
    e.cyc  = c + lat;
    e.data = (rd && !(CHK && bad(ra))) ? mdl[idx(ra)] : '0;
    e.err  = mdl_err;
    expq.push_back(e);
    repeat (lat) begin
      step();
      Dcache_wb_addr_i  = $urandom;
      Dcache_rd_addr_i  = $urandom;
      Dcache_data_ram_i = {$urandom, $urandom, $urandom, $urandom};
    end
    step();
    if (!hold_extra) begin
      Dcache_wb_req_i = 1'b0;
      Dcache_rd_req_i = 1'b0;
    end
    step();
    Dcache_wb_req_i = 1'b0;
    Dcache_rd_req_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {20'h0, 8'($urandom_range(0, DEPTH - 1)), 4'h0};
    if ($urandom_range(0, 7) == 0) a[3:0] = 4'($urandom_range(1, 15));
    if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int c, r1, n0;
    logic [127:0] d;
    rst = 1'b1;
    Dcache_rd_req_i = 1'b0;
    Dcache_wb_req_i = 1'b0;
    Dcache_rd_addr_i = '0;
    Dcache_wb_addr_i = '0;
    Dcache_data_ram_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(ram_ready_o), 128'd0);
    chk("reset_data", ram_data_o, '0);
`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
    chk("reset_err", 128'(ram_err_o), 128'd0);
`endif
    @(negedge clk) rst = 1'b0;
    step();

    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 1) ? LIT1 : (i == 4) ? LIT11 : (i == 5) ? LITC : {$urandom, $urandom, $urandom, $urandom};
      txn(1'b1, 1'b0, 32'(i) << 4, d, 32'h0, 1'b0, c);
    end

    txn(1'b0, 1'b1, 32'h0, '0, 32'h0000_0010, 1'b0, c);
    chk("rd_latency", 128'(last_rdy_cyc - c), 128'd5);
    chk("rd_data", last_rdy_data, LIT1);

    txn(1'b1, 1'b0, 32'h0000_0020, LITA, 32'h0, 1'b0, c);
    chk("wb_latency", 128'(last_rdy_cyc - c), 128'd5);
    chk("wb_data_zero", last_rdy_data, '0);
    txn(1'b0, 1'b1, 32'h0, '0, 32'h0000_0020, 1'b0, c);
    chk("wb_readback", last_rdy_data, LITA);

    txn(1'b1, 1'b1, 32'h0000_0030, LIT5, 32'h0000_0040, 1'b0, c);
    chk("wbrd_latency", 128'(last_rdy_cyc - c), 128'd9);
    chk("wbrd_data", last_rdy_data, LIT11);
    txn(1'b0, 1'b1, 32'h0, '0, 32'h0000_0030, 1'b0, c);
    chk("wbrd_readback", last_rdy_data, LIT5);

    n0 = ready_cnt;
    txn(1'b0, 1'b1, 32'h0, '0, 32'h0000_0010, 1'b1, c);
    r1 = last_rdy_cyc;
    txn(1'b0, 1'b1, 32'h0, '0, 32'h0000_0020, 1'b0, c);
    chk("holdoff_spacing", 128'(last_rdy_cyc - r1), 128'd7);
    chk("holdoff_pulses", 128'(ready_cnt - n0), 128'd2);

    // Reset lands while the write-back counter reads 2; nothing may be written or acknowledged.
    n0 = ready_cnt;
    Dcache_wb_req_i   = 1'b1;
    Dcache_wb_addr_i  = 32'h0000_0050;
    Dcache_data_ram_i = {4{32'hDEADBEEF}};
    step();
    step();
    rst = 1'b1;
    Dcache_wb_req_i = 1'b0;
    mdl_err = 1'b0;
    step();
    step();
    @(negedge clk) rst = 1'b0;
    step();
    repeat (L + 3) step();
    chk("reset_no_ready", 128'(ready_cnt - n0), 128'd0);
    txn(1'b0, 1'b1, 32'h0, '0, 32'h0000_0050, 1'b0, c);
    chk("reset_line_kept", last_rdy_data, LITC);

    txn(1'b0, 1'b1, 32'h0, '0, 32'h0000_1010, 1'b0, c);
    chk("wrap_latency", 128'(last_rdy_cyc - c), 128'd5);
`ifdef DCACHE_LINE_RAM_ADDR_CHECK_EN
    chk("wrap_data_suppressed", last_rdy_data, '0);
    chk("wrap_err", 128'(ram_err_o), 128'd1);
`else
    chk("wrap_data", last_rdy_data, LIT1);
`endif

    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, rand_addr(), {$urandom, $urandom, $urandom, $urandom},
          rand_addr(), 1'($urandom_range(0, 1)), c);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    chk("queue_drained", 128'(expq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_line_ram.md
Name: dcache_line_ram

Overview:
- Line-granular data memory that sits directly downstream of rv32core's Dcache port.
- Consumes the Dcache refill request (rd), the writeback request (wb) and the 128-bit writeback line.
- Returns a refill line plus a one-cycle ready pulse to rv32core's ram_data_i / ram_ready_i inputs.
- Models fixed access latency so the Dcache stall path in Flow_Ctrl is exercised realistically.

Parameters:
- DEPTH, 256: number of 128-bit lines; power of two.
- ADDR_W, 8: line-index width; must equal log2(DEPTH).
- LATENCY, 4: wait cycles per access phase; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- Dcache_rd_req_i  input  1  refill request; level, held until ready.
- Dcache_rd_addr_i  input  32  refill byte address.
- Dcache_wb_req_i  input  1  writeback request; level, held until ready.
- Dcache_wb_addr_i  input  32  writeback byte address.
- Dcache_data_ram_i  input  128  writeback line.
- ram_data_o  output  128  refill line; valid only while ram_ready_o=1.
- ram_ready_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous, active-high: state=IDLE, cnt=0, ram_ready_o=0, ram_data_o=0. Memory array is not reset.
- Line index is addr[ADDR_W+3:4]. Bits [3:0] and bits above ADDR_W+3 are ignored, so addresses wrap modulo DEPTH lines.
- A transaction is sampled in IDLE only. Its type is wb-only, rd-only, or wb+rd (both requests high in the same cycle).
- On entry, addresses and the wb line are latched into internal registers. Later input changes mid-transaction are ignored.
- State IDLE:
  - wb_req=1 -> WB_WAIT.
  - wb_req=0 and rd_req=1 -> RD_WAIT.
  - Otherwise stay in IDLE.
  - cnt is loaded with LATENCY-1 on exit.
- State WB_WAIT:
  - cnt decrements each cycle.
  - At cnt=0 the latched line is written to mem[wb_idx].
  - Then go to RD_WAIT (cnt reloaded) if rd was latched, else RESP.
- State RD_WAIT:
  - cnt decrements each cycle.
  - At cnt=0, register mem[rd_idx] into ram_data_o and go to RESP.
- State RESP:
  - ram_ready_o=1 for exactly this cycle, then go to HOLDOFF.
  - ram_data_o holds the refill line for rd and wb+rd transactions, and 0 for wb-only.
- State HOLDOFF:
  - One cycle that ignores requests, absorbing a request still high in the cycle after ready. Then go to IDLE.
  - Requesters must drop their requests the cycle after ready.
- Latency from the request-sample edge to the ready cycle:
  - rd-only: LATENCY+1 cycles.
  - wb-only: LATENCY+1 cycles.
  - wb+rd: 2*LATENCY+1 cycles.
  - Minimum spacing between ready pulses: LATENCY+3 cycles.
- wb+rd to the same line index: the write lands first, so the read returns the newly written line.
- ram_data_o returns to 0 the cycle after RESP.
- Reset mid-transaction: the transaction is abandoned and no ready is issued. A write not yet at cnt=0 is not performed.

Optional Feature:
- Macro: DCACHE_LINE_RAM_ADDR_CHECK_EN.
- When defined, adds output port ram_err_o (1 bit, reset 0, sticky until rst).
- ram_err_o sets on a sampled transaction whose used address has nonzero bits [3:0] or nonzero bits above ADDR_W+3.
- Such an access is suppressed: the write is dropped and the read returns 0. Timing and the ready pulse are unchanged.
- When undefined, there is no ram_err_o port and addresses wrap silently.

Decomposition:
- Package dcache_line_ram_pkg holds:
  - State encoding: IDLE=0, WB_WAIT=1, RD_WAIT=2, RESP=3, HOLDOFF=4 (3 bits).
  - LINE_W=128 and OFFSET_W=4 constants.
  - Transaction-type typedef.
- One sub-module, line_ram_array: synchronous-read/synchronous-write 128-bit x DEPTH storage with a single port, usable by synthesis as inferred block RAM.
- The FSM and latency counter stay in the top module.

Test Plan:
- Reset, then rd_req with addr 0x0000_0010, memory preloaded with line 1 = 0x0123...CDEF -> ram_ready_o high at cycle LATENCY+1 (5) with that data, low otherwise.
- wb_req with addr 0x0000_0020 and data 0xAAAA...AAAA, then rd of 0x20 -> ready pulse after 5 cycles with ram_data_o=0; the subsequent read returns 0xAAAA...AAAA.
- wb+rd together: wb 0x30 with data 0x5555...5555, rd 0x40 holding line 0x1111...1111 -> a single ready pulse at cycle 9 with data 0x1111...1111; line 3 now reads 0x5555...5555.
- Request held one cycle past ready -> no second transaction; the next is accepted only after HOLDOFF, giving ready spacing of 7 cycles.
- Reset asserted at WB_WAIT cnt=2 -> no ready pulse; the target line keeps its old value.
- Wrap and feature check: rd 0x0000_1010 returns line 1.
  - With DCACHE_LINE_RAM_ADDR_CHECK_EN defined, the same read instead sets ram_err_o=1 and returns 0; ready timing is unchanged.
